// File: rtl/leaf_message_responder.sv
// Leaf endpoint of the root-hub control protocol. It accepts START and measurement-header
// words, launches and times one decode per header, and returns a single result word.
module leaf_message_responder #(
  parameter logic [7:0] LEAF_ID                 = 8'd1,
  parameter logic [7:0] START_DECODING_MSG      = 8'd1,
  parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'd2,
  parameter logic [7:0] RESULT_MSG              = 8'd3,
  parameter logic [7:0] REPORTING_LEAF_ID       = 8'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        decoder_start,
  output logic        fusion_stage,
  output logic        measurement_fusion_on,
  output logic        multi_fpga_run,
  input  logic        decoder_done,
  input  logic [7:0]  decoder_iterations
);

  typedef enum logic [1:0] {IDLE, WAIT_MEAS, DECODE, SEND_RESULT} state_e;

  typedef struct packed {
    logic [7:0]  dest;
    logic [7:0]  src;
    logic [7:0]  iter;
    logic [15:0] cyc;
    logic [15:0] rsvd;
    logic [7:0]  mtype;
  } result_t;

  state_e      state_q, state_d;
  logic        rx_ready_q, rx_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [63:0] tx_data_q, tx_data_d;
  logic        decoder_start_q, decoder_start_d;
  logic        fusion_stage_q, fusion_stage_d;
  logic        fusion_on_q, fusion_on_d;
  logic        multi_q, multi_d;
  logic        exp_stage_q, exp_stage_d;
  logic [15:0] cyc_acc_q, cyc_acc_d;
  logic [7:0]  iter_acc_q, iter_acc_d;

  logic        rx_fire, addressed, is_start, is_hdr;
  logic [8:0]  iter_sum;
  result_t     result;

  // Bits of the incoming word the protocol leaves unused at the leaf.
  logic unused_rx_bits;
  assign unused_rx_bits = ^{rx_data[55:48], rx_data[39:2]};

  assign rx_fire   = rx_valid && rx_ready_q;
  assign addressed = (rx_data[63:56] == 8'hff) || (rx_data[63:56] == LEAF_ID);
  assign is_start  = rx_fire && addressed && (rx_data[47:40] == START_DECODING_MSG);
  assign is_hdr    = rx_fire && addressed && (rx_data[47:40] == MEASUREMENT_DATA_HEADER);
  assign iter_sum  = {1'b0, iter_acc_q} + {1'b0, decoder_iterations};

  always_comb begin
    state_d         = state_q;
    fusion_stage_d  = fusion_stage_q;
    fusion_on_d     = fusion_on_q;
    multi_d         = multi_q;
    exp_stage_d     = exp_stage_q;
    cyc_acc_d       = cyc_acc_q;
    iter_acc_d      = iter_acc_q;
    decoder_start_d = 1'b0;

    case (state_q)
      IDLE, WAIT_MEAS: begin
        if (is_start) begin
          fusion_on_d = rx_data[1];
          multi_d     = rx_data[0];
          cyc_acc_d   = '0;
          iter_acc_d  = '0;
          exp_stage_d = 1'b0;
          state_d     = WAIT_MEAS;
        end else if (is_hdr && state_q == WAIT_MEAS && rx_data[0] == exp_stage_q) begin
          fusion_stage_d  = rx_data[0];
          decoder_start_d = 1'b1;
          state_d         = DECODE;
        end
      end
      DECODE: begin
        if (cyc_acc_q != 16'hffff) cyc_acc_d = cyc_acc_q + 16'd1;
        // The done pulse cannot belong to this decode in its launch cycle.
        if (decoder_done && !decoder_start_q) begin
          iter_acc_d = iter_sum[8] ? 8'hff : iter_sum[7:0];
          if (fusion_on_q && !fusion_stage_q) begin
            exp_stage_d = 1'b1;
            state_d     = WAIT_MEAS;
          end else if (multi_q && (LEAF_ID != REPORTING_LEAF_ID)) begin
            state_d = IDLE;
          end else begin
            state_d = SEND_RESULT;
          end
        end
      end
      SEND_RESULT: begin
        if (tx_valid_q && tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    result.dest  = 8'h00;
    result.src   = LEAF_ID;
    result.iter  = iter_acc_d;
    result.cyc   = cyc_acc_d;
    result.rsvd  = 16'h0000;
    result.mtype = RESULT_MSG;

    rx_ready_d = (state_d == IDLE) || (state_d == WAIT_MEAS);
    tx_valid_d = (state_d == SEND_RESULT);
    tx_data_d  = tx_data_q;
    if (state_d == SEND_RESULT && state_q != SEND_RESULT) tx_data_d = result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      rx_ready_q      <= 1'b0;
      tx_valid_q      <= 1'b0;
      tx_data_q       <= '0;
      decoder_start_q <= 1'b0;
      fusion_stage_q  <= 1'b0;
      fusion_on_q     <= 1'b0;
      multi_q         <= 1'b0;
      exp_stage_q     <= 1'b0;
      cyc_acc_q       <= '0;
      iter_acc_q      <= '0;
    end else begin
      state_q         <= state_d;
      rx_ready_q      <= rx_ready_d;
      tx_valid_q      <= tx_valid_d;
      tx_data_q       <= tx_data_d;
      decoder_start_q <= decoder_start_d;
      fusion_stage_q  <= fusion_stage_d;
      fusion_on_q     <= fusion_on_d;
      multi_q         <= multi_d;
      exp_stage_q     <= exp_stage_d;
      cyc_acc_q       <= cyc_acc_d;
      iter_acc_q      <= iter_acc_d;
    end
  end

  assign rx_ready              = rx_ready_q;
  assign tx_valid              = tx_valid_q;
  assign tx_data               = tx_data_q;
  assign decoder_start         = decoder_start_q;
  assign fusion_stage          = fusion_stage_q;
  assign measurement_fusion_on = fusion_on_q;
  assign multi_fpga_run        = multi_q;

endmodule

// File: tb/tb_leaf_message_responder.sv
// Directed bench for leaf_message_responder: a vector table of single decodes plus
// hand-written fusion, multi-FPGA, backpressure, filtering and reset sequences.
module tb_leaf_message_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic        decoder_done;
  logic [7:0]  decoder_iterations;

  logic        rx_ready, tx_valid, decoder_start, fusion_stage, fusion_on, multi;
  logic [63:0] tx_data;
  logic        rx_ready2, tx_valid2, decoder_start2, fusion_stage2, fusion_on2, multi2;
  logic [63:0] tx_data2;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int tx2_cycles = 0;

  always #5 clk = ~clk;

  leaf_message_responder #(.LEAF_ID(8'd1)) u_dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .decoder_start(decoder_start), .fusion_stage(fusion_stage),
    .measurement_fusion_on(fusion_on), .multi_fpga_run(multi),
    .decoder_done(decoder_done), .decoder_iterations(decoder_iterations));

  leaf_message_responder #(.LEAF_ID(8'd2)) u_dut2 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready),
    .decoder_start(decoder_start2), .fusion_stage(fusion_stage2),
    .measurement_fusion_on(fusion_on2), .multi_fpga_run(multi2),
    .decoder_done(decoder_done), .decoder_iterations(decoder_iterations));

  always @(posedge clk) begin
    if (!reset && tx_valid && tx_ready) xfers <= xfers + 1;
    if (tx_valid2) tx2_cycles <= tx2_cycles + 1;
  end

  typedef struct {
    logic [63:0] start_w;
    logic [63:0] hdr_w;
    int          k;
    logic [7:0]  it;
    logic [63:0] exp_tx;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [63:0] w);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = w;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: rx_ready %b, want 1", rx_ready);
    end
    tick();
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  // Called in the first DECODE cycle; raises done in the k-th DECODE cycle.
  task automatic do_decode(input int k, input logic [7:0] it);
    chk("decoder_start_first", decoder_start, 1);
    for (int c = 1; c <= k; c++) begin
      chk("rx_ready_in_decode", rx_ready, 0);
      if (c > 1) chk("decoder_start_once", decoder_start, 0);
      if (c == k) begin
        decoder_done       = 1'b1;
        decoder_iterations = it;
      end
      tick();
    end
    decoder_done       = 1'b0;
    decoder_iterations = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int x0, t0;
    logic [63:0] held;

    vecs[0] = '{64'hffff0100_00000000, 64'hffff0200_00000000, 6,  8'h07, 64'h00010700_06000003};
    vecs[1] = '{64'h01000100_00000000, 64'h01000200_00000000, 2,  8'h00, 64'h00010000_02000003};
    vecs[2] = '{64'hffff0100_00000000, 64'hffff0200_00000000, 3,  8'hff, 64'h0001ff00_03000003};
    vecs[3] = '{64'h01000100_00000000, 64'hff000200_00000000, 40, 8'h10, 64'h00011000_28000003};

    reset = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1;
    decoder_done = 1'b0; decoder_iterations = '0;
    tick(); tick();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 64'h0);
    chk("rst_decoder_start", decoder_start, 0);
    chk("rst_fusion_stage", fusion_stage, 0);
    chk("rst_flags", {fusion_on, multi}, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_rx_ready", rx_ready, 1);

    for (int v = 0; v < 4; v++) begin
      send_word(vecs[v].start_w);
      send_word(vecs[v].hdr_w);
      do_decode(vecs[v].k, vecs[v].it);
      chk("vec_tx_valid", tx_valid, 1);
      chk("vec_tx_data", tx_data, vecs[v].exp_tx);
      chk("vec_rx_ready_send", rx_ready, 0);
      tick();
      chk("vec_tx_valid_drop", tx_valid, 0);
      chk("vec_rx_ready_idle", rx_ready, 1);
    end

    // Fusion: stage-1 header first is dropped, result only after stage 1.
    do_reset();
    send_word(64'hffff0100_00000002);
    chk("fus_flag_on", fusion_on, 1);
    chk("fus_multi_off", multi, 0);
    send_word(64'hffff0200_00000001);
    chk("fus_wrong_stage_drop", decoder_start, 0);
    chk("fus_wrong_stage_ready", rx_ready, 1);
    send_word(64'hffff0200_00000000);
    chk("fus_stage0", fusion_stage, 0);
    do_decode(4, 8'd3);
    chk("fus_no_tx_after_s0", tx_valid, 0);
    chk("fus_back_to_wait", rx_ready, 1);
    send_word(64'hffff0200_00000001);
    chk("fus_stage1", fusion_stage, 1);
    do_decode(6, 8'd2);
    chk("fus_tx_valid", tx_valid, 1);
    chk("fus_tx_data", tx_data, 64'h00010500_0a000003);
    tick();

    // Multi-FPGA: leaf 2 stays silent, leaf 1 reports.
    do_reset();
    t0 = tx2_cycles;
    send_word(64'hffff0100_00000001);
    chk("mfp_multi_flag", multi, 1);
    send_word(64'hffff0200_00000000);
    chk("mfp_leaf2_start", decoder_start2, 1);
    do_decode(3, 8'd4);
    chk("mfp_leaf1_tx_valid", tx_valid, 1);
    chk("mfp_leaf1_tx_data", tx_data, 64'h00010400_03000003);
    chk("mfp_leaf2_idle", rx_ready2, 1);
    tick(); tick(); tick();
    chk("mfp_leaf2_no_tx", tx2_cycles - t0, 0);

    // Backpressure: result held 10 cycles, one transfer on release.
    do_reset();
    send_word(64'hffff0100_00000000);
    send_word(64'hffff0200_00000000);
    tx_ready = 1'b0;
    x0 = xfers;
    do_decode(2, 8'd1);
    held = tx_data;
    chk("bp_tx_data", held, 64'h00010100_02000003);
    for (int c = 0; c < 10; c++) begin
      chk("bp_tx_valid_hold", tx_valid, 1);
      chk("bp_tx_data_stable", tx_data, held);
      chk("bp_rx_ready_low", rx_ready, 0);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_tx_valid_drop", tx_valid, 0);
    tick(); tick();
    chk("bp_one_transfer", xfers - x0, 1);

    // Filtering: foreign dest and unknown type are consumed and ignored.
    do_reset();
    send_word(64'h05ff0100_00000003);
    chk("flt_dest_flags", {fusion_on, multi}, 0);
    chk("flt_dest_ready", rx_ready, 1);
    send_word(64'hffff7e00_00000003);
    chk("flt_type_flags", {fusion_on, multi}, 0);
    chk("flt_type_ready", rx_ready, 1);
    send_word(64'hffff0200_00000000);
    chk("flt_hdr_in_idle", decoder_start, 0);
    send_word(64'hffff0100_00000000);
    send_word(64'hffff0200_00000000);
    do_decode(2, 8'd2);
    chk("flt_tx_data", tx_data, 64'h00010200_02000003);
    tick();

    // Reset two cycles into DECODE, then a stray done.
    do_reset();
    x0 = xfers;
    send_word(64'hffff0100_00000002);
    send_word(64'hffff0200_00000000);
    chk("rmd_decoder_start", decoder_start, 1);
    tick();
    reset = 1'b1;
    tick();
    chk("rmd_rx_ready", rx_ready, 0);
    chk("rmd_tx_valid", tx_valid, 0);
    chk("rmd_tx_data", tx_data, 64'h0);
    chk("rmd_decoder_start_rst", decoder_start, 0);
    chk("rmd_flags", {fusion_on, multi, fusion_stage}, 0);
    reset = 1'b0;
    decoder_done = 1'b1;
    decoder_iterations = 8'd9;
    tick();
    decoder_done = 1'b0;
    decoder_iterations = '0;
    tick();
    chk("rmd_stray_done_tx", tx_valid, 0);
    chk("rmd_idle_ready", rx_ready, 1);
    send_word(64'hffff0100_00000000);
    send_word(64'hffff0200_00000000);
    do_decode(3, 8'd1);
    chk("rmd_fresh_tx_data", tx_data, 64'h00010100_03000003);
    tick();
    chk("rmd_transfers", xfers - x0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
